// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_pkg;

   // Number of select codes swept for the default 4-bit select width.
   localparam int unsigned N_CODES = 16;

   // Width of the per-code hold counter; holds SETTLE-1 for SETTLE up to 15.
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StDone
   } state_e;

endpackage

// File: rtl/settle_cnt.sv
// Per-code hold counter: loadable, decrementing, with a zero flag.
module settle_cnt #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] cnt,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;

   // Load has priority over decrement; decrement saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   // Expose count and zero flag to the sequencer.
   always_comb begin
      cnt  = cnt_q;
      zero = (cnt_q == '0);
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps a select code across a function block, holding each code for SETTLE
// cycles, captures the resulting truth table and compares it to a golden one.
module truth_table_scanner
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [2**WIDTH-1:0]   expected,
   input  logic                  f,
   output logic [WIDTH-1:0]      W,
   output logic                  En,
   output logic                  busy,
   output logic                  done,
   output logic [2**WIDTH-1:0]   table_out,
   output logic                  table_valid,
   output logic [2**WIDTH-1:0]   mismatch,
   output logic                  pass
);

   localparam int unsigned NCodes = 2**WIDTH;
   localparam logic [WIDTH-1:0] LastCode = WIDTH'(NCodes - 1);
   localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(SETTLE - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   w_q, w_d;
   logic               en_q, en_d;
   logic [NCodes-1:0]  table_q, table_d;
   logic               valid_q, valid_d;

   logic               cnt_load;
   logic               cnt_dec;
   logic               cnt_zero;
   logic [CNT_W-1:0]   cnt_val;

   settle_cnt #(
      .WIDTH(CNT_W)
   ) u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (HoldLoad),
      .dec      (cnt_dec),
      .cnt      (cnt_val),
      .zero     (cnt_zero)
   );

   // State and datapath registers; reset discards any partial sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         w_q     <= '0;
         en_q    <= 1'b0;
         table_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         en_q    <= en_d;
         table_q <= table_d;
         valid_q <= valid_d;
      end
   end

   // Sequencer: next state, select code, capture and counter control.
   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      en_d     = en_q;
      table_d  = table_q;
      valid_d  = valid_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // abort is deliberately not looked at here
            if (start) begin
               state_d  = StSettle;
               w_d      = '0;
               en_d     = 1'b1;
               cnt_load = 1'b1;
               valid_d  = 1'b0;
               table_d  = '0;
            end
         end
         StSettle: begin
            if (abort) begin
               state_d = StIdle;
               en_d    = 1'b0;
               w_d     = '0;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               table_d[w_q] = f;
               if (w_q == LastCode) begin
                  // W stays at the last code; it never wraps
                  state_d = StDone;
                  en_d    = 1'b0;
               end else begin
                  w_d      = w_q + WIDTH'(1);
                  cnt_load = 1'b1;
               end
            end
         end
         StDone: begin
            valid_d = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from registered state; compare gated by table_valid.
   always_comb begin
      W           = w_q;
      En          = en_q;
      busy        = (state_q == StSettle);
      done        = (state_q == StDone);
      table_out   = table_q;
      table_valid = valid_q;
      mismatch    = valid_q ? (table_q ^ expected) : '0;
      pass        = valid_q && (mismatch == '0);
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: SETTLE=2 and SETTLE=1 instances.
module tb_truth_table_scanner;

   logic        clk;
   logic        rst_n;

   // SETTLE=2 instance
   logic        start2, abort2, f2;
   logic [15:0] expected2;
   logic [3:0]  W2;
   logic        En2, busy2, done2, valid2, pass2;
   logic [15:0] table2, mismatch2;
   int          mode;

   // SETTLE=1 instance
   logic        start1, abort1, f1;
   logic [15:0] expected1;
   logic [3:0]  W1;
   logic        En1, busy1, done1, valid1, pass1;
   logic [15:0] table1, mismatch1;

   int checks;
   int errors;

   truth_table_scanner #(
      .SETTLE (2),
      .WIDTH  (4)
   ) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start2),
      .abort       (abort2),
      .expected    (expected2),
      .f           (f2),
      .W           (W2),
      .En          (En2),
      .busy        (busy2),
      .done        (done2),
      .table_out   (table2),
      .table_valid (valid2),
      .mismatch    (mismatch2),
      .pass        (pass2)
   );

   truth_table_scanner #(
      .SETTLE (1),
      .WIDTH  (4)
   ) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start1),
      .abort       (abort1),
      .expected    (expected1),
      .f           (f1),
      .W           (W1),
      .En          (En1),
      .busy        (busy1),
      .done        (done1),
      .table_out   (table1),
      .table_valid (valid1),
      .mismatch    (mismatch1),
      .pass        (pass1)
   );

   // Function blocks under control
   always_comb begin
      f2 = (mode == 0) ? W2[0] : (W2 == 4'd5);
      f1 = ~W1[3];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts edges after the start edge until done2 is seen; -1 on timeout.
   task automatic wait_done2(output int at);
      at = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (done2) begin
            at = i;
            break;
         end
      end
   endtask

   task automatic wait_w2(input logic [3:0] v, output int ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (W2 == v) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic pulse_start2();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
   endtask

   initial begin
      int at;
      int ok;
      int seen;
      checks    = 0;
      errors    = 0;
      mode      = 0;
      rst_n     = 1'b1;
      start2    = 1'b0;
      abort2    = 1'b0;
      expected2 = 16'hAAAA;
      start1    = 1'b0;
      abort1    = 1'b0;
      expected1 = 16'h00FF;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy2, 1'b0);
      check("rst_W", W2, 4'd0);
      check("rst_En", En2, 1'b0);
      check("rst_valid", valid2, 1'b0);
      check("rst_table", table2, 16'h0);
      check("rst_pass", pass2, 1'b0);
      #20 rst_n = 1'b1;
      tick();
      tick();
      check("idle_no_start_busy", busy2, 1'b0);

      // Basic sweep, f = W[0]
      pulse_start2();
      check("start_busy", busy2, 1'b1);
      check("start_En", En2, 1'b1);
      check("start_W", W2, 4'd0);
      tick();
      check("edge1_W", W2, 4'd0);
      tick();
      check("edge2_W", W2, 4'd1);
      wait_done2(at);
      check("basic_done_edge", at, 32 - 2);
      check("basic_done_busy", busy2, 1'b0);
      check("basic_done_En", En2, 1'b0);
      check("basic_no_wrap_W", W2, 4'd15);
      check("basic_valid_during_done", valid2, 1'b0);
      tick();
      check("basic_done_pulse", done2, 1'b0);
      check("basic_valid", valid2, 1'b1);
      check("basic_table", table2, 16'hAAAA);
      check("basic_pass", pass2, 1'b1);
      check("basic_mismatch", mismatch2, 16'h0);
      tick();
      tick();
      check("basic_hold_table", table2, 16'hAAAA);
      check("basic_hold_W", W2, 4'd15);

      // Compare, f = (W==5)
      mode      = 1;
      expected2 = 16'h0020;
      pulse_start2();
      check("cmp_valid_cleared", valid2, 1'b0);
      check("cmp_mismatch_gated", mismatch2, 16'h0);
      wait_done2(at);
      check("cmp_done_edge", at, 32);
      tick();
      check("cmp_table", table2, 16'h0020);
      check("cmp_pass", pass2, 1'b1);
      check("cmp_mismatch", mismatch2, 16'h0);
      expected2 = 16'h0021;
      #1;
      check("cmp2_pass", pass2, 1'b0);
      check("cmp2_mismatch", mismatch2, 16'h0001);

      // Abort at W=7
      mode      = 0;
      expected2 = 16'hAAAA;
      pulse_start2();
      wait_w2(4'd7, ok);
      check("abort_reach_W7", ok, 1);
      abort2 = 1'b1;
      tick();
      abort2 = 1'b0;
      check("abort_busy", busy2, 1'b0);
      check("abort_En", En2, 1'b0);
      check("abort_W", W2, 4'd0);
      check("abort_valid", valid2, 1'b0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done2 || busy2) seen = 1;
      end
      check("abort_no_done", seen, 0);
      check("abort_valid_later", valid2, 1'b0);

      // abort+start in IDLE starts; start pulse mid-sweep ignored
      abort2 = 1'b1;
      start2 = 1'b1;
      tick();
      abort2 = 1'b0;
      start2 = 1'b0;
      check("abort_start_idle_busy", busy2, 1'b1);
      at = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (i == 6) begin
            check("midstart_W3", W2, 4'd3);
            start2 = 1'b1;
         end
         if (i == 7) start2 = 1'b0;
         if (done2) begin
            at = i;
            break;
         end
      end
      check("midstart_done_edge", at, 32);
      tick();
      check("midstart_table", table2, 16'hAAAA);

      // Reset mid-sweep at W=9
      pulse_start2();
      wait_w2(4'd9, ok);
      check("rst_reach_W9", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy2, 1'b0);
      check("midrst_W", W2, 4'd0);
      check("midrst_En", En2, 1'b0);
      check("midrst_table", table2, 16'h0);
      check("midrst_done", done2, 1'b0);
      #3 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done2 || busy2) seen = 1;
      end
      check("midrst_no_done", seen, 0);
      pulse_start2();
      wait_done2(at);
      check("midrst_restart_done", at, 32);
      tick();
      check("midrst_restart_table", table2, 16'hAAAA);
      check("midrst_restart_pass", pass2, 1'b1);

      // start held high: back-to-back sweeps
      start2 = 1'b1;
      tick();
      wait_done2(at);
      check("held_first_done", at, 32);
      wait_done2(at);
      check("held_period", at, 34);
      start2 = 1'b0;
      tick();
      tick();
      check("held_stop_busy", busy2, 1'b0);

      // SETTLE=1, f = ~W[3]
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      at = -1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (done1) begin
            at = i;
            break;
         end
      end
      check("s1_done_edge", at, 16);
      tick();
      check("s1_table", table1, 16'h00FF);
      check("s1_pass", pass1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
